// File: rtl/alu_sequencer_if.sv
// Instruction handshake and status bundle between an instruction source and alu_sequencer.
interface alu_sequencer_if #(
    parameter int RA_W = 2
);
    logic            instr_valid;
    logic            instr_ready;
    logic [3:0]      instr_op;
    logic [RA_W-1:0] instr_dst;
    logic [RA_W-1:0] instr_src1;
    logic [RA_W-1:0] instr_src2;
    logic [3:0]      instr_imm;
    logic            done;
    logic            err;
    logic [3:0]      rd_data;
    logic            ovf_last;
    logic            ovf_sticky;
    logic            ovf_clr;

    modport master (
        output instr_valid, instr_op, instr_dst, instr_src1, instr_src2, instr_imm, ovf_clr,
        input  instr_ready, done, err, rd_data, ovf_last, ovf_sticky
    );

    modport slave (
        input  instr_valid, instr_op, instr_dst, instr_src1, instr_src2, instr_imm, ovf_clr,
        output instr_ready, done, err, rd_data, ovf_last, ovf_sticky
    );
endinterface

// File: rtl/alu_sequencer.sv
// Three-state instruction sequencer: reads operands from a small register file, fires one
// ALU enable for one cycle, writes the result back and pulses done.
module alu_sequencer #(
    parameter int NUM_REGS = 4,
    parameter int RA_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_sequencer_if.slave       bus,
    output logic [12:0]          alu_en,
    output logic [3:0]           alu_rd1,
    output logic [3:0]           alu_rd2,
    input  logic [3:0]           alu_result,
    input  logic                 alu_overflow
);
    localparam logic [3:0] OP_WR   = 4'd0;
    localparam logic [3:0] OP_READ = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd9;
    localparam logic [3:0] OP_SUB  = 4'd10;
    localparam logic [3:0] OP_LAST = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [3:0]      regs [NUM_REGS];
    logic [3:0]      op_q;
    logic [RA_W-1:0] dst_q;
    logic            is_arith;
    logic            is_illegal;

    assign is_arith   = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign is_illegal = (op_q > OP_LAST);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (bus.instr_valid && bus.instr_ready) state_next = S_EXEC;
            S_EXEC:  state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they line up with the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            bus.instr_ready <= 1'b1;
            bus.done        <= 1'b0;
            bus.err         <= 1'b0;
        end else begin
            state           <= state_next;
            bus.instr_ready <= (state_next == S_IDLE);
            bus.done        <= (state_next == S_DONE);
            bus.err         <= (state_next == S_DONE) && is_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            op_q           <= '0;
            dst_q          <= '0;
            alu_en         <= '0;
            alu_rd1        <= '0;
            alu_rd2        <= '0;
            bus.rd_data    <= '0;
            bus.ovf_last   <= 1'b0;
            bus.ovf_sticky <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.instr_valid && bus.instr_ready) begin
                        op_q    <= bus.instr_op;
                        dst_q   <= bus.instr_dst;
                        alu_rd1 <= (bus.instr_op == OP_WR) ? bus.instr_imm : regs[bus.instr_src1];
                        alu_rd2 <= regs[bus.instr_src2];
                        alu_en  <= (bus.instr_op <= OP_LAST) ? (13'd1 << bus.instr_op) : 13'd0;
                    end
                end
                S_EXEC: begin
                    bus.rd_data  <= alu_result;
                    bus.ovf_last <= alu_overflow && is_arith;
                    alu_en       <= '0;
                    if ((op_q != OP_READ) && !is_illegal) regs[dst_q] <= alu_result;
                end
                default: ;
            endcase

            // A new overflow outranks a simultaneous clear so no event is ever lost.
            if ((state == S_EXEC) && is_arith && alu_overflow) bus.ovf_sticky <= 1'b1;
            else if (bus.ovf_clr)                               bus.ovf_sticky <= 1'b0;
        end
    end
endmodule
